rgb_frame_ctrl: RTL and testbench
=================================

// Module: rgb_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the byte->RGB packer (packet2rgb).
//  - Hunts for a sync byte in the raw RX byte stream.
//  - Forwards exactly 3*H_PIX*V_LINES payload bytes to the packer.
//  - Counts returned pixels and tags each with x/y, SOF, EOL and EOF.
//  - Recovers from stalled links via a timeout and a packer re-align pulse.
// PARAMETERS
//  H_PIX        640        pixels per line
//  V_LINES      480        lines per frame
//  SYNC_BYTE    8'hA5      frame start marker
//  TIMEOUT_CYC  1_000_000  max idle cycles mid-frame before abort
// PORTS
//  i_clk          in   1   system clock
//  i_rst          in   1   synchronous reset, active-high
//  i_rx_data      in   8   raw byte from link
//  i_rx_valid     in   1   i_rx_data qualifier
//  i_start        in   1   arm pulse; also clears o_err_timeout
//  i_cont         in   1   1 = re-hunt after a frame; 0 = go idle
//  i_rgb_valid    in   1   pixel-done strobe from packer
//  o_byte_data    out  8   payload byte to packer
//  o_byte_valid   out  1   payload byte qualifier
//  o_conv_rst     out  1   1-cycle packer phase re-align pulse
//  o_pix_valid    out  1   tagged pixel strobe
//  o_x            out  $clog2(H_PIX)    pixel column
//  o_y            out  $clog2(V_LINES)  pixel row
//  o_sof / o_eol / o_eof   out  1  first pixel / last in line / last in frame
//  o_frame_done   out  1   1-cycle pulse at frame completion
//  o_busy         out  1   state != IDLE
//  o_err_timeout  out  1   sticky timeout flag
// BEHAVIOUR
//  Reset
//  - Reset is synchronous; i_rst takes effect on the next edge.
//  - On reset: state IDLE; all outputs 0; all counters 0.
//  - i_rst mid-frame aborts silently. No o_conv_rst pulse (the packer shares i_rst).
//  States
//  - IDLE: the first i_start pulse goes to HUNT and clears o_err_timeout.
//    Later i_start pulses are ignored outside IDLE.
//  - HUNT: all bytes are dropped.
//    On i_rx_valid && i_rx_data==SYNC_BYTE: go to PAYLOAD, clear byte, pixel and timeout
//    counters, and pulse o_conv_rst in the next cycle.
//  - PAYLOAD: each valid byte is registered to o_byte_data/o_byte_valid (1-cycle latency)
//    and byte_cnt increments.
//    SYNC_BYTE values are ordinary payload here.
//    On acceptance of byte 3*H_PIX*V_LINES-1 go to DRAIN.
//  - DRAIN: no forwarding; RX bytes are dropped. Wait until pix_cnt == H_PIX*V_LINES, then DONE.
//    If the last pixel already arrived in PAYLOAD, DRAIN lasts 1 cycle.
//  - DONE: one cycle. o_frame_done=1 in that cycle.
//    Next state is HUNT if i_cont=1, else IDLE.
//  Pixel tagging
//  - Active in PAYLOAD and DRAIN only. i_rgb_valid is ignored in other states and once
//    pix_cnt has reached H_PIX*V_LINES.
//  - 1-cycle latency: o_pix_valid follows i_rgb_valid, and o_x/o_y give that pixel's
//    coordinates.
//  - o_sof = (x==0 && y==0). o_eol = (x==H_PIX-1). o_eof = o_eol && (y==V_LINES-1).
//    All three are gated by o_pix_valid.
//  - At x==H_PIX-1, x wraps to 0 and y increments. y is never incremented past V_LINES-1.
//  Timeout
//  - The counter runs in PAYLOAD and DRAIN.
//  - It clears on i_rx_valid (PAYLOAD) or i_rgb_valid (either state).
//  - At TIMEOUT_CYC-1: set o_err_timeout, pulse o_conv_rst, go to HUNT.
//    Counters are cleared; no o_frame_done.
//  - If the clearing event and the terminal count coincide, the event wins (no timeout).
//  Widths and arithmetic
//  - byte_cnt width: $clog2(3*H_PIX*V_LINES). pix_cnt width: $clog2(H_PIX*V_LINES+1).
//  - Counters saturate, never wrap.
// STRUCTURE
//  - rgb_frame_pkg holds: state enum {IDLE,HUNT,PAYLOAD,DRAIN,DONE};
//    localparams FRAME_PIX and FRAME_BYTES; coord typedefs.
//  - One sub-module, frame_xy_counter, owns the x/y wrap logic and the SOF/EOL/EOF
//    tags, registered.
//  - FSM, byte counter and timeout live in the top module.
// TESTING  (H_PIX=4, V_LINES=2, TIMEOUT_CYC=16, SYNC_BYTE=8'hA5)
//  - Nominal: i_start, bytes 00,11,A5 then 24 payload bytes 01..18.
//    -> First 2 bytes dropped; o_conv_rst pulses once; exactly 24 o_byte_valid with
//       data 01..18.
//    -> With 8 i_rgb_valid: o_sof on pixel 0, o_eol on pixels 3 and 7, o_eof on
//       pixel 7 (x=3,y=1), then o_frame_done.
//  - Payload containing A5 as byte 5 -> forwarded as data; no restart.
//  - i_cont=1 with two back-to-back frames -> second frame starts at x=0,y=0 with o_sof.
//  - Stall after 10 payload bytes for 16 cycles -> o_err_timeout=1, o_conv_rst pulse,
//    state HUNT, no o_frame_done.
//    -> A following i_start clears the flag; the next frame completes normally.
//  - 9th i_rgb_valid after o_eof, and i_rgb_valid in HUNT -> no o_pix_valid.
//  - i_rst asserted mid-PAYLOAD -> next cycle all outputs 0, o_busy=0, no o_conv_rst.

Source files
------------

// File: rtl/rgb_frame_pkg.sv
// ============================================================================
// Module : rgb_frame_pkg
// Brief  : Shared state encoding, frame-size constants and coordinate types
//          for the RGB frame sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HUNT    = 3'd1,
        PAYLOAD = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_H_PIX   = 640;
    localparam int DEF_V_LINES = 480;
    localparam int FRAME_PIX   = DEF_H_PIX * DEF_V_LINES;
    localparam int FRAME_BYTES = 3 * FRAME_PIX;

    typedef logic [$clog2(DEF_H_PIX)-1:0]   coord_x_t;
    typedef logic [$clog2(DEF_V_LINES)-1:0] coord_y_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_frame_ctrl_xy_counter.sv
// ============================================================================
// Module : frame_xy_counter
// Brief  : Walks x/y across the frame per accepted pixel and emits registered
//          coordinates with SOF/EOL/EOF tags one cycle after the step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_xy_counter
    import rgb_frame_pkg::*;
#(
    parameter int H_PIX   = DEF_H_PIX,
    parameter int V_LINES = DEF_V_LINES
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_step,
    output logic                       o_pix_valid,
    output logic [$clog2(H_PIX)-1:0]   o_x,
    output logic [$clog2(V_LINES)-1:0] o_y,
    output logic                       o_sof,
    output logic                       o_eol,
    output logic                       o_eof
);

    localparam int XW = $clog2(H_PIX);
    localparam int YW = $clog2(V_LINES);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_x_out;
    logic [YW-1:0] r_y_out;
    logic          r_pix_valid;
    logic          r_sof;
    logic          r_eol;
    logic          r_eof;
    logic          w_last_x;
    logic          w_last_y;

    assign w_last_x = (r_x == XW'(H_PIX - 1));
    assign w_last_y = (r_y == YW'(V_LINES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_pix_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_pix_valid <= i_step;
            r_sof       <= i_step && (r_x == '0) && (r_y == '0);
            r_eol       <= i_step && w_last_x;
            r_eof       <= i_step && w_last_x && w_last_y;
            if (i_step) begin
                r_x_out <= r_x;
                r_y_out <= r_y;
            end
            if (i_clr) begin
                r_x <= '0;
                r_y <= '0;
            end else if (i_step) begin
                // y sticks on the last line so stray steps cannot leave the frame
                if (w_last_x) begin
                    r_x <= '0;
                    if (!w_last_y) begin
                        r_y <= r_y + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign o_pix_valid = r_pix_valid;
    assign o_x         = r_x_out;
    assign o_y         = r_y_out;
    assign o_sof       = r_sof;
    assign o_eol       = r_eol;
    assign o_eof       = r_eof;

endmodule

`default_nettype wire

// File: rtl/rgb_frame_ctrl.sv
// ============================================================================
// Module : rgb_frame_ctrl
// Brief  : Frame sequencer: sync hunt, payload forwarding to the RGB packer,
//          pixel tagging and stall recovery via timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_frame_ctrl
    import rgb_frame_pkg::*;
#(
    parameter int         H_PIX       = DEF_H_PIX,
    parameter int         V_LINES     = DEF_V_LINES,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_start,
    input  logic                       i_cont,
    input  logic                       i_rgb_valid,
    output logic [7:0]                 o_byte_data,
    output logic                       o_byte_valid,
    output logic                       o_conv_rst,
    output logic                       o_pix_valid,
    output logic [$clog2(H_PIX)-1:0]   o_x,
    output logic [$clog2(V_LINES)-1:0] o_y,
    output logic                       o_sof,
    output logic                       o_eol,
    output logic                       o_eof,
    output logic                       o_frame_done,
    output logic                       o_busy,
    output logic                       o_err_timeout
);

    localparam int c_FRAME_PIX   = H_PIX * V_LINES;
    localparam int c_FRAME_BYTES = 3 * c_FRAME_PIX;
    localparam int BW            = cnt_width(c_FRAME_BYTES);
    localparam int PW            = cnt_width(c_FRAME_PIX + 1);
    localparam int TW            = cnt_width(TIMEOUT_CYC);

    state_t        r_state,     w_state;
    logic [BW-1:0] r_byte_cnt,  w_byte_cnt;
    logic [PW-1:0] r_pix_cnt,   w_pix_cnt;
    logic [TW-1:0] r_to_cnt,    w_to_cnt;
    logic          r_err,       w_err;
    logic          r_conv_rst,  w_conv_rst;
    logic [7:0]    r_byte_data, w_byte_data;
    logic          r_byte_valid, w_byte_valid;
    logic          w_xy_clr;

    logic          w_run;
    logic          w_pix_full;
    logic          w_pix_step;
    logic          w_activity;

    assign w_run      = (r_state == PAYLOAD) || (r_state == DRAIN);
    assign w_pix_full = (r_pix_cnt == PW'(c_FRAME_PIX));
    assign w_pix_step = w_run && i_rgb_valid && !w_pix_full;
    assign w_activity = i_rgb_valid || ((r_state == PAYLOAD) && i_rx_valid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
            r_conv_rst   <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_byte_cnt   <= w_byte_cnt;
            r_pix_cnt    <= w_pix_cnt;
            r_to_cnt     <= w_to_cnt;
            r_err        <= w_err;
            r_conv_rst   <= w_conv_rst;
            r_byte_data  <= w_byte_data;
            r_byte_valid <= w_byte_valid;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_byte_cnt   = r_byte_cnt;
        w_pix_cnt    = r_pix_cnt;
        w_to_cnt     = '0;
        w_err        = r_err;
        w_conv_rst   = 1'b0;
        w_byte_data  = r_byte_data;
        w_byte_valid = 1'b0;
        w_xy_clr     = 1'b0;

        if (w_pix_step) begin
            w_pix_cnt = r_pix_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state = HUNT;
                    w_err   = 1'b0;
                end
            end
            HUNT: begin
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    w_state    = PAYLOAD;
                    w_byte_cnt = '0;
                    w_pix_cnt  = '0;
                    w_conv_rst = 1'b1;
                    w_xy_clr   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (i_rx_valid) begin
                    w_byte_data  = i_rx_data;
                    w_byte_valid = 1'b1;
                    if (r_byte_cnt == BW'(c_FRAME_BYTES - 1)) begin
                        w_state = DRAIN;
                    end else begin
                        w_byte_cnt = r_byte_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_pix_full) begin
                    w_state = DONE;
                end
            end
            DONE: begin
                w_state = i_cont ? HUNT : IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        // Any activity restarts the idle count, so it wins over the terminal count.
        if (w_run && !w_activity && !((r_state == DRAIN) && w_pix_full)) begin
            if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                w_state    = HUNT;
                w_err      = 1'b1;
                w_conv_rst = 1'b1;
                w_byte_cnt = '0;
                w_pix_cnt  = '0;
                w_xy_clr   = 1'b1;
            end else begin
                w_to_cnt = r_to_cnt + 1'b1;
            end
        end
    end

    frame_xy_counter #(
        .H_PIX   (H_PIX),
        .V_LINES (V_LINES)
    ) u_xy (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_xy_clr),
        .i_step      (w_pix_step),
        .o_pix_valid (o_pix_valid),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_sof       (o_sof),
        .o_eol       (o_eol),
        .o_eof       (o_eof)
    );

    assign o_byte_data   = r_byte_data;
    assign o_byte_valid  = r_byte_valid;
    assign o_conv_rst    = r_conv_rst;
    assign o_frame_done  = (r_state == DONE);
    assign o_busy        = (r_state != IDLE);
    assign o_err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_ctrl.sv
// ============================================================================
// Module : tb_rgb_frame_ctrl
// Brief  : Directed self-checking bench for rgb_frame_ctrl on a 4x2 frame.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic       i_start = 1'b0;
    logic       i_cont = 1'b0;
    logic       i_rgb_valid = 1'b0;
    logic [7:0] o_byte_data;
    logic       o_byte_valid, o_conv_rst, o_pix_valid;
    logic [1:0] o_x;
    logic [0:0] o_y;
    logic       o_sof, o_eol, o_eof, o_frame_done, o_busy, o_err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_frame_ctrl #(
        .H_PIX       (4),
        .V_LINES     (2),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_start       (i_start),
        .i_cont        (i_cont),
        .i_rgb_valid   (i_rgb_valid),
        .o_byte_data   (o_byte_data),
        .o_byte_valid  (o_byte_valid),
        .o_conv_rst    (o_conv_rst),
        .o_pix_valid   (o_pix_valid),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_sof         (o_sof),
        .o_eol         (o_eol),
        .o_eof         (o_eof),
        .o_frame_done  (o_frame_done),
        .o_busy        (o_busy),
        .o_err_timeout (o_err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rgb;
        logic pv;
        int   x;
        int   y;
        logic sof;
        logic eol;
        logic eof;
        logic done;
        logic busy;
    } pix_vec_t;

    pix_vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte_valid"}, o_byte_valid, 0);
        chk({tag, "_byte_data"},  o_byte_data, 0);
        chk({tag, "_conv_rst"},   o_conv_rst, 0);
        chk({tag, "_pix_valid"},  o_pix_valid, 0);
        chk({tag, "_x"},          o_x, 0);
        chk({tag, "_y"},          o_y, 0);
        chk({tag, "_sof"},        o_sof, 0);
        chk({tag, "_eol"},        o_eol, 0);
        chk({tag, "_eof"},        o_eof, 0);
        chk({tag, "_done"},       o_frame_done, 0);
        chk({tag, "_busy"},       o_busy, 0);
        chk({tag, "_err"},        o_err_timeout, 0);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Sync byte then n payload bytes (value i+1, or A5 at index a5_idx), each checked.
    task automatic send_payload(input int n, input int a5_idx);
        logic [7:0] d;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hA5;
        tick();
        chk("sync_conv_rst", o_conv_rst, 1);
        chk("sync_not_fwd", o_byte_valid, 0);
        for (int i = 0; i < n; i++) begin
            d = (i == a5_idx) ? 8'hA5 : 8'(i + 1);
            i_rx_data = d;
            tick();
            chk("byte_valid", o_byte_valid, 1);
            chk("byte_data", o_byte_data, d);
            chk("payload_conv_rst", o_conv_rst, 0);
        end
        i_rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int a5_idx, input logic cont);
        i_cont = cont;
        send_payload(24, a5_idx);
        for (int p = 0; p < 8; p++) begin
            i_rgb_valid = 1'b1;
            tick();
            chk("pix_valid", o_pix_valid, 1);
            chk("pix_x", o_x, p % 4);
            chk("pix_y", o_y, p / 4);
            chk("pix_sof", o_sof, (p == 0) ? 1 : 0);
            chk("pix_eol", o_eol, ((p % 4) == 3) ? 1 : 0);
            chk("pix_eof", o_eof, (p == 7) ? 1 : 0);
        end
        i_rgb_valid = 1'b0;
        for (int k = 0; k < 8 && !o_frame_done; k++) tick();
        chk("frame_done", o_frame_done, 1);
        tick();
        chk("done_one_cycle", o_frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;

        //            rgb pv x  y  sof eol eof done busy
        tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // Nominal frame: two junk bytes dropped, sync, 24 bytes, tagged pixels
        i_cont = 1'b0;
        pulse_start();
        chk("start_busy", o_busy, 1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h00;
        tick();
        chk("drop0_valid", o_byte_valid, 0);
        chk("drop0_conv_rst", o_conv_rst, 0);
        i_rx_data = 8'h11;
        tick();
        chk("drop1_valid", o_byte_valid, 0);
        send_payload(24, -1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hEE;
        for (int i = 0; i < 11; i++) begin
            i_rgb_valid = tbl[i].rgb;
            tick();
            chk("tbl_pix_valid", o_pix_valid, tbl[i].pv);
            if (tbl[i].pv) begin
                chk("tbl_x", o_x, tbl[i].x);
                chk("tbl_y", o_y, tbl[i].y);
            end
            chk("tbl_sof", o_sof, tbl[i].sof);
            chk("tbl_eol", o_eol, tbl[i].eol);
            chk("tbl_eof", o_eof, tbl[i].eof);
            chk("tbl_done", o_frame_done, tbl[i].done);
            chk("tbl_busy", o_busy, tbl[i].busy);
            chk("tbl_drain_drop", o_byte_valid, 0);
        end
        i_rx_valid  = 1'b0;
        i_rgb_valid = 1'b0;

        // Back-to-back frames, first with A5 as payload byte 5
        pulse_start();
        run_frame(4, 1'b1);
        chk("cont_rehunt_busy", o_busy, 1);
        run_frame(-1, 1'b0);
        chk("cont_end_idle", o_busy, 0);

        // Stall after 10 payload bytes
        pulse_start();
        send_payload(10, -1);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_done = saw_done | o_frame_done;
        end
        chk("pre_timeout_err", o_err_timeout, 0);
        tick();
        saw_done = saw_done | o_frame_done;
        chk("timeout_err", o_err_timeout, 1);
        chk("timeout_conv_rst", o_conv_rst, 1);
        chk("timeout_busy", o_busy, 1);
        chk("timeout_no_done", saw_done, 0);
        tick();
        chk("timeout_conv_rst_pulse", o_conv_rst, 0);
        i_rgb_valid = 1'b1;
        tick();
        chk("hunt_rgb_ignored", o_pix_valid, 0);
        i_rgb_valid = 1'b0;
        run_frame(-1, 1'b0);
        chk("err_sticky", o_err_timeout, 1);
        chk("after_recover_idle", o_busy, 0);
        pulse_start();
        chk("start_clears_err", o_err_timeout, 0);
        chk("restart_busy", o_busy, 1);

        // Reset in the middle of a payload
        send_payload(5, -1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h42;
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        i_rx_valid = 1'b0;
        tick();
        chk("midrst_no_conv_rst", o_conv_rst, 0);
        chk("midrst_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
